// File: rtl/attn_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// attn_ctrl_pkg
//   Shared types and constants for the Q/K/V projection + attention phase
//   sequencer.
//     phase_e      : FSM state encoding, also driven out on the phase port
//     port_sel_e   : owner of the shared Q/K/V output SRAM ports
//     ctrl_out_t   : bundle of all registered controller outputs
//     decode_outputs() : next-state to output decode
// ---------------------------------------------------------------------------
package attn_ctrl_pkg;

    localparam int DRAIN_CYC_DEF = 2;
    localparam int TIMEOUT_DEF   = 4096;

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_LOAD    = 3'd1,
        PH_PROJ    = 3'd2,
        PH_DRAIN   = 3'd3,
        PH_ATTN    = 3'd4,
        PH_READOUT = 3'd5,
        PH_ERR     = 3'd7
    } phase_e;

    // PS_NONE makes the SRAM wrapper force WEB high, so nobody can write.
    typedef enum logic [1:0] {
        PS_HOST = 2'd0,
        PS_PROJ = 2'd1,
        PS_ATTN = 2'd2,
        PS_NONE = 2'd3
    } port_sel_e;

    typedef struct packed {
        logic      load_grant;
        logic      proj_en;
        logic      attn_start;
        port_sel_e port_sel;
        phase_e    phase;
        logic      busy;
        logic      done;
        logic      err;
    } ctrl_out_t;

    localparam ctrl_out_t CTRL_OUT_RST = '{
        load_grant: 1'b0,
        proj_en:    1'b0,
        attn_start: 1'b0,
        port_sel:   PS_HOST,
        phase:      PH_IDLE,
        busy:       1'b0,
        done:       1'b0,
        err:        1'b0
    };

    // Outputs are decoded from the state being entered so that they are
    // registered yet line up with the state register cycle for cycle.
    function automatic ctrl_out_t decode_outputs(input phase_e nx,
                                                 input phase_e cur,
                                                 input logic   done_ev);
        ctrl_out_t o;
        o            = CTRL_OUT_RST;
        o.phase      = nx;
        o.load_grant = (nx == PH_LOAD);
        o.proj_en    = (nx == PH_PROJ);
        o.attn_start = (nx == PH_ATTN) && (cur != PH_ATTN);
        o.busy       = (nx != PH_IDLE) && (nx != PH_ERR);
        o.err        = (nx == PH_ERR);
        o.done       = done_ev;
        case (nx)
            PH_PROJ:            o.port_sel = PS_PROJ;
            PH_ATTN:            o.port_sel = PS_ATTN;
            PH_DRAIN, PH_ERR:   o.port_sel = PS_NONE;
            default:            o.port_sel = PS_HOST;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer
//   Clearable saturating up-counter with a terminal-count flag. Used by the
//   sequencer both to time the write-to-read drain and as the phase watchdog.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     clr        : synchronous clear (wins over en)
//     en         : count this cycle; the counter stops at LIMIT
//     expire     : high in the cycle whose closing edge brings the count to
//                  LIMIT (or while already saturated and enabled), so the
//                  consumer can change state on that very edge
// ---------------------------------------------------------------------------
module phase_timer #(
    parameter int LIMIT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int            W    = $clog2(LIMIT) + 1;
    localparam logic [W-1:0]  LIM  = W'(LIMIT);
    localparam logic [W-1:0]  LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LIM)) begin
            count <= count + W'(1);
        end
    end

    assign expire = en && (count >= LAST);

endmodule

// File: rtl/attn_phase_ctrl.sv
// ---------------------------------------------------------------------------
// attn_phase_ctrl
//   Phase sequencer for the Q/K/V projection + attention pipeline:
//   IDLE -> LOAD -> PROJ -> DRAIN -> ATTN -> READOUT -> IDLE, with ERR on a
//   watchdog expiry in PROJ or ATTN. Owns the select of the shared Q/K/V
//   output SRAM ports and issues the attention start pulse.
//   Parameters:
//     DRAIN_CYC : idle cycles between last projection write and attn_start
//     TIMEOUT   : max cycles allowed in PROJ or ATTN
//   Ports:
//     clk, rst_n                 : clock, async active-low reset
//     start                      : run request, honoured only in IDLE
//     load_done                  : host finished loading input/weights
//     finished_q/_k/_v           : projection unit completion (level/pulse)
//     attn_done                  : attention engine completion pulse
//     host_release               : host finished reading results
//     abort                      : synchronous return to IDLE from anywhere
//     load_grant, proj_en        : phase enables
//     attn_start                 : one-cycle attention start pulse
//     port_sel                   : output SRAM owner (HOST/PROJ/ATTN/NONE)
//     phase                      : current state encoding
//     busy, done, err            : status
// ---------------------------------------------------------------------------
module attn_phase_ctrl
    import attn_ctrl_pkg::*;
#(
    parameter int DRAIN_CYC = DRAIN_CYC_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       load_done,
    input  logic       finished_q,
    input  logic       finished_k,
    input  logic       finished_v,
    input  logic       attn_done,
    input  logic       host_release,
    input  logic       abort,
    output logic       load_grant,
    output logic       proj_en,
    output logic       attn_start,
    output logic [1:0] port_sel,
    output logic [2:0] phase,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // Reset asserts asynchronously but releases on a clock edge, so every
    // flop below leaves reset in the same cycle.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    phase_e    state, state_nx;
    ctrl_out_t out_q, out_nx;
    logic      fq, fk, fv;
    logic      all_fin;
    logic      state_chg;
    logic      done_ev;
    logic      wd_expire;
    logic      drain_expire;

    // A finish input seen in the current PROJ cycle counts immediately, so
    // the last finish moves to DRAIN on the edge that samples it.
    assign all_fin   = (fq | finished_q) & (fk | finished_k) & (fv | finished_v);
    assign state_chg = (state_nx != state);
    assign done_ev   = (state == PH_READOUT) && host_release && !abort;

    phase_timer #(.LIMIT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_int_n),
        .clr    (state_chg),
        .en     ((state == PH_PROJ) || (state == PH_ATTN)),
        .expire (wd_expire)
    );

    phase_timer #(.LIMIT(DRAIN_CYC)) u_drain (
        .clk    (clk),
        .rst_n  (rst_int_n),
        .clr    (state_chg),
        .en     (state == PH_DRAIN),
        .expire (drain_expire)
    );

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state <= PH_IDLE;
            out_q <= CTRL_OUT_RST;
        end else begin
            state <= state_nx;
            out_q <= out_nx;
        end
    end

    // Sticky finish flags: cleared on PROJ entry, only collect while in PROJ.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            fq <= 1'b0;
            fk <= 1'b0;
            fv <= 1'b0;
        end else if (state_chg && (state_nx == PH_PROJ)) begin
            fq <= 1'b0;
            fk <= 1'b0;
            fv <= 1'b0;
        end else if (state == PH_PROJ) begin
            fq <= fq | finished_q;
            fk <= fk | finished_k;
            fv <= fv | finished_v;
        end
    end

    // Priority inside each state: abort, then completion, then watchdog.
    always_comb begin
        // NOTE: defaults first so every path assigns every variable and no
        // latch is inferred.
        state_nx = state;
        if (abort) begin
            state_nx = PH_IDLE;
        end else begin
            case (state)
                PH_IDLE:    if (start)        state_nx = PH_LOAD;
                PH_LOAD:    if (load_done)    state_nx = PH_PROJ;
                PH_PROJ: begin
                    if (all_fin)              state_nx = PH_DRAIN;
                    else if (wd_expire)       state_nx = PH_ERR;
                end
                PH_DRAIN:   if (drain_expire) state_nx = PH_ATTN;
                PH_ATTN: begin
                    if (attn_done)            state_nx = PH_READOUT;
                    else if (wd_expire)       state_nx = PH_ERR;
                end
                PH_READOUT: if (host_release) state_nx = PH_IDLE;
                PH_ERR:                       state_nx = PH_ERR;
                default:                      state_nx = PH_IDLE;
            endcase
        end
        out_nx = decode_outputs(state_nx, state, done_ev);
    end

    assign load_grant = out_q.load_grant;
    assign proj_en    = out_q.proj_en;
    assign attn_start = out_q.attn_start;
    assign port_sel   = out_q.port_sel;
    assign phase      = out_q.phase;
    assign busy       = out_q.busy;
    assign done       = out_q.done;
    assign err        = out_q.err;

endmodule

// File: tb/tb_attn_phase_ctrl.sv
// ---------------------------------------------------------------------------
// tb_attn_phase_ctrl
//   Two instances share all inputs: dut_a (TIMEOUT 4096) carries the long
//   nominal runs and is watched by a scoreboard of phase transitions,
//   attn_start and done pulses; dut_b (TIMEOUT 16) covers the watchdog.
// ---------------------------------------------------------------------------
module tb_attn_phase_ctrl;
    import attn_ctrl_pkg::*;

    localparam int DRAIN = 2;
    localparam int TO_A  = 4096;
    localparam int TO_B  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, load_done = 1'b0, attn_done = 1'b0;
    logic finished_q = 1'b0, finished_k = 1'b0, finished_v = 1'b0;
    logic host_release = 1'b0, abort = 1'b0;

    logic       lg_a, pe_a, as_a, busy_a, done_a, err_a;
    logic [1:0] ps_a;
    logic [2:0] ph_a;
    logic       lg_b, pe_b, as_b, busy_b, done_b, err_b;
    logic [1:0] ps_b;
    logic [2:0] ph_b;

    attn_phase_ctrl #(.DRAIN_CYC(DRAIN), .TIMEOUT(TO_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .load_done(load_done),
        .finished_q(finished_q), .finished_k(finished_k), .finished_v(finished_v),
        .attn_done(attn_done), .host_release(host_release), .abort(abort),
        .load_grant(lg_a), .proj_en(pe_a), .attn_start(as_a), .port_sel(ps_a),
        .phase(ph_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    attn_phase_ctrl #(.DRAIN_CYC(DRAIN), .TIMEOUT(TO_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .load_done(load_done),
        .finished_q(finished_q), .finished_k(finished_k), .finished_v(finished_v),
        .attn_done(attn_done), .host_release(host_release), .abort(abort),
        .load_grant(lg_b), .proj_en(pe_b), .attn_start(as_b), .port_sel(ps_b),
        .phase(ph_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard for dut_a.
    int         exp_phase_q[$];
    int         exp_start_q[$];
    int         exp_done_q[$];
    bit         mon_en = 1'b0;
    logic [2:0] last_ph = 3'd0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (ph_a !== last_ph) begin
                if (exp_phase_q.size() == 0) check("phase_unexpected", ph_a, last_ph);
                else                         check("phase_seq", ph_a, exp_phase_q.pop_front());
            end
            if (as_a !== 1'b0) begin
                if (exp_start_q.size() == 0) check("attn_start_unexpected", cyc, -1);
                else                         check("attn_start_cyc", cyc, exp_start_q.pop_front());
                check("attn_start_port", ps_a, PS_ATTN);
            end
            if (done_a !== 1'b0) begin
                if (exp_done_q.size() == 0) check("done_unexpected", cyc, -1);
                else                        check("done_cyc", cyc, exp_done_q.pop_front());
                check("done_busy", busy_a, 0);
            end
        end
        last_ph = ph_a;
    end

    task automatic push_phases(input int p0, input int p1, input int p2,
                               input int p3, input int p4, input int p5, input int n);
        int p[6];
        p = '{p0, p1, p2, p3, p4, p5};
        for (int i = 0; i < n; i++) exp_phase_q.push_back(p[i]);
    endtask

    task automatic check_sb_empty(input string tag);
        check({tag, "_phase_left"}, exp_phase_q.size(), 0);
        check({tag, "_start_left"}, exp_start_q.size(), 0);
        check({tag, "_done_left"},  exp_done_q.size(),  0);
        exp_phase_q.delete();
        exp_start_q.delete();
        exp_done_q.delete();
    endtask

    task automatic idle_both();
        mon_en = 1'b0;
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_nominal(input string tag);
        int c0;
        c0 = 0;
        mon_en = 1'b1;
        push_phases(1, 2, 3, 4, 5, 0, 6);
        for (int t = 0; t <= 116; t++) begin
            @(negedge clk);
            if (t == 0) c0 = cyc;
            if (t == 1) begin
                check({tag, "_lg"},   lg_a, 1);
                check({tag, "_busy"}, busy_a, 1);
                check({tag, "_ps_load"}, ps_a, PS_HOST);
            end
            if (t == 12) begin
                check({tag, "_proj_en"}, pe_a, 1);
                check({tag, "_ps_proj"}, ps_a, PS_PROJ);
            end
            if (t == 31) begin
                check({tag, "_drain_pe"}, pe_a, 0);
                check({tag, "_ps_drain"}, ps_a, PS_NONE);
            end
            if (t == 40) check({tag, "_attn_once"}, as_a, 0);
            if (t == 112) check({tag, "_done_once"}, done_a, 0);
            start        = (t == 0);
            load_done    = (t == 5);
            finished_q   = (t == 20);
            finished_k   = (t == 25);
            finished_v   = (t == 30);
            attn_done    = (t == 100);
            host_release = (t == 110);
            if (t == 30)  exp_start_q.push_back(c0 + 33);
            if (t == 110) exp_done_q.push_back(c0 + 111);
        end
        check_sb_empty(tag);
    endtask

    initial begin
        int c0;
        c0 = 0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_phase", ph_a, 0);
        check("rst_ps", ps_a, 0);
        check("rst_flags_a", {lg_a, pe_a, as_a, busy_a, done_a, err_a}, 0);
        check("rst_flags_b", {lg_b, pe_b, as_b, busy_b, done_b, err_b, ps_b, ph_b}, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Nominal run.
        run_nominal("nom");

        // Reverse-order one-cycle finishes, one of them during LOAD.
        idle_both();
        mon_en = 1'b1;
        push_phases(1, 2, 3, 4, 5, 0, 6);
        for (int t = 0; t <= 40; t++) begin
            @(negedge clk);
            if (t == 0) c0 = cyc;
            if (t == 13) check("rev_still_proj", ph_a, PH_PROJ);
            if (t == 15) begin
                check("rev_drain", ph_a, PH_DRAIN);
                check("rev_ps_none", ps_a, PS_NONE);
            end
            start        = (t == 0);
            finished_q   = (t == 2) || (t == 14);
            load_done    = (t == 4);
            finished_v   = (t == 8);
            finished_k   = (t == 10);
            attn_done    = (t == 30);
            host_release = (t == 35);
            if (t == 14) exp_start_q.push_back(c0 + 17);
            if (t == 35) exp_done_q.push_back(c0 + 36);
        end
        check_sb_empty("rev");

        // Watchdog in PROJ on dut_b: finished_k never comes.
        idle_both();
        for (int t = 0; t <= 24; t++) begin
            @(negedge clk);
            if (t == 18) check("to_still_proj", ph_b, PH_PROJ);
            if (t == 19) begin
                check("to_phase_err", ph_b, PH_ERR);
                check("to_err", err_b, 1);
                check("to_ps_none", ps_b, PS_NONE);
                check("to_busy", busy_b, 0);
            end
            if (t == 23) check("to_start_ignored", ph_b, PH_ERR);
            start      = (t == 0) || (t == 21);
            load_done  = (t == 2);
            finished_q = (t == 5);
            finished_v = (t == 6);
        end
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("to_abort_phase", ph_b, PH_IDLE);
        check("to_abort_err", err_b, 0);

        // attn_done on the cycle the watchdog reaches TIMEOUT on dut_b.
        idle_both();
        for (int t = 0; t <= 26; t++) begin
            @(negedge clk);
            if (t == 7)  check("tie_attn_start", as_b, 1);
            if (t == 22) check("tie_still_attn", ph_b, PH_ATTN);
            if (t == 23) begin
                check("tie_readout", ph_b, PH_READOUT);
                check("tie_no_err", err_b, 0);
            end
            if (t == 25) check("tie_done", done_b, 1);
            start        = (t == 0);
            load_done    = (t == 2);
            finished_q   = (t == 4);
            finished_k   = (t == 4);
            finished_v   = (t == 4);
            attn_done    = (t == 22);
            host_release = (t == 24);
        end

        // Reset asserted during ATTN on dut_a, then a fresh run.
        idle_both();
        mon_en = 1'b1;
        push_phases(1, 2, 3, 4, 0, 0, 5);
        for (int t = 0; t <= 12; t++) begin
            @(negedge clk);
            if (t == 0) c0 = cyc;
            start      = (t == 0);
            load_done  = (t == 2);
            finished_q = (t == 5);
            finished_k = (t == 5);
            finished_v = (t == 5);
            if (t == 5) exp_start_q.push_back(c0 + 8);
        end
        check("rst_pre_attn", ph_a, PH_ATTN);
        #2 rst_n = 1'b0;
        #1;
        check("arst_phase", ph_a, 0);
        check("arst_flags", {lg_a, pe_a, as_a, busy_a, done_a, err_a, ps_a}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_sb_empty("arst");
        run_nominal("post_rst");

        // Abort in DRAIN.
        idle_both();
        mon_en = 1'b1;
        push_phases(1, 2, 3, 0, 0, 0, 4);
        for (int t = 0; t <= 20; t++) begin
            @(negedge clk);
            if (t == 5) check("abd_in_drain", ph_a, PH_DRAIN);
            if (t == 6) begin
                check("abd_idle", ph_a, PH_IDLE);
                check("abd_ps_host", ps_a, PS_HOST);
                check("abd_busy", busy_a, 0);
            end
            start      = (t == 0);
            load_done  = (t == 2);
            finished_q = (t == 4);
            finished_k = (t == 4);
            finished_v = (t == 4);
            abort      = (t == 5);
        end
        check_sb_empty("abd");
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cyc %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
